rob_multi: RTL and testbench

- Parametrised reorder buffer, successor to the single-issue ROB in the writeback stage.
- Allocates up to ALLOC_W instructions per cycle from decode and accepts WB_PORTS writebacks per cycle.
- Commits up to COMMIT_W completed instructions in order per cycle.
- On a committed taken branch, squashes younger entries and reports store-buffer slots to discard; full/empty come from an explicit occupancy counter.

---
 rtl/rob_multi.sv | 226 ++++++++++++++++++++++
 tb/tb_rob_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: wide allocate, multi-port writeback, in-order wide commit with
// taken-branch squash. Optional perf counters are enabled by defining ROB_PERF_CNT_EN.
module rob_multi #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned ALLOC_W   = 2,
  parameter int unsigned COMMIT_W  = 2,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned SB_SIZE   = 8,
  localparam int unsigned IDX_W    = $clog2(ROB_DEPTH),
  localparam int unsigned SBI_W    = $clog2(SB_SIZE)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [ALLOC_W-1:0]          alloc_valid_i,
  input  logic [ALLOC_W*32-1:0]       alloc_pc_i,
  input  logic [ALLOC_W*5-1:0]        alloc_rd_i,
  input  logic [ALLOC_W-1:0]          alloc_we_i,
  input  logic [ALLOC_W-1:0]          alloc_store_i,
  output logic                        alloc_ready_o,
  output logic [ALLOC_W*IDX_W-1:0]    alloc_idx_o,
  input  logic [WB_PORTS-1:0]         wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0]   wb_idx_i,
  input  logic [WB_PORTS*32-1:0]      wb_result_i,
  input  logic [WB_PORTS*32-1:0]      wb_new_pc_i,
  input  logic [WB_PORTS-1:0]         wb_taken_i,
  input  logic [WB_PORTS*SBI_W-1:0]   wb_sb_idx_i,
  output logic [COMMIT_W-1:0]         commit_valid_o,
  output logic [COMMIT_W*32-1:0]      commit_pc_o,
  output logic [COMMIT_W*5-1:0]       commit_rd_o,
  output logic [COMMIT_W-1:0]         commit_we_o,
  output logic [COMMIT_W*32-1:0]      commit_result_o,
  output logic [COMMIT_W-1:0]         commit_store_o,
  output logic [COMMIT_W*SBI_W-1:0]   commit_sb_idx_o,
  output logic                        redirect_valid_o,
  output logic [31:0]                 redirect_pc_o,
  output logic [SB_SIZE-1:0]          discard_sb_o,
  output logic [IDX_W:0]              count_o,
  output logic                        empty_o,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]                 perf_commit_o,
  output logic [31:0]                 perf_full_stall_o,
`endif
  output logic                        full_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [ROB_DEPTH-1:0] r_valid;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_we;
  logic [ROB_DEPTH-1:0] r_store;
  logic [ROB_DEPTH-1:0] r_taken;
  logic [31:0]          r_pc     [ROB_DEPTH];
  logic [4:0]           r_rd     [ROB_DEPTH];
  logic [31:0]          r_result [ROB_DEPTH];
  logic [31:0]          r_new_pc [ROB_DEPTH];
  logic [SBI_W-1:0]     r_sb_idx [ROB_DEPTH];
  logic [IDX_W-1:0]     r_head;
  logic [IDX_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [COMMIT_W-1:0]  w_commit;
  logic [ROB_DEPTH-1:0] w_commit_mask;
  logic [CNT_W-1:0]     w_commit_n;
  logic [CNT_W-1:0]     w_alloc_n;
  logic                 w_alloc_ready;
  logic                 w_redirect;
  logic [31:0]          w_redirect_pc;
  logic                 w_squash;
  logic [SB_SIZE-1:0]   w_discard;
  logic [IDX_W-1:0]     w_cidx;
  logic                 w_run;

  // Credit check uses registered occupancy only
  assign w_alloc_ready = (r_count <= CNT_W'(ROB_DEPTH - ALLOC_W));

  always_comb begin
    w_alloc_n   = '0;
    alloc_idx_o = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_idx_o[k*IDX_W +: IDX_W] = r_tail + IDX_W'(k);
      if (w_alloc_ready && alloc_valid_i[k]) w_alloc_n = w_alloc_n + CNT_W'(1);
    end
  end

  // In-order commit: stops at the first incomplete entry or just after a taken branch
  always_comb begin
    w_commit        = '0;
    w_commit_mask   = '0;
    w_commit_n      = '0;
    w_redirect      = 1'b0;
    w_redirect_pc   = '0;
    w_cidx          = '0;
    w_run           = ~flush_i;
    commit_pc_o     = '0;
    commit_rd_o     = '0;
    commit_we_o     = '0;
    commit_result_o = '0;
    commit_store_o  = '0;
    commit_sb_idx_o = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      w_cidx = r_head + IDX_W'(k);
      if (w_run && r_valid[w_cidx] && r_done[w_cidx] && (CNT_W'(k) < r_count)) begin
        w_commit[k]                       = 1'b1;
        w_commit_mask[w_cidx]             = 1'b1;
        w_commit_n                        = w_commit_n + CNT_W'(1);
        commit_pc_o[k*32 +: 32]           = r_pc[w_cidx];
        commit_rd_o[k*5 +: 5]             = r_rd[w_cidx];
        commit_we_o[k]                    = r_we[w_cidx];
        commit_result_o[k*32 +: 32]       = r_result[w_cidx];
        commit_store_o[k]                 = r_store[w_cidx];
        commit_sb_idx_o[k*SBI_W +: SBI_W] = r_sb_idx[w_cidx];
        if (r_taken[w_cidx]) begin
          w_redirect    = 1'b1;
          w_redirect_pc = r_new_pc[w_cidx];
          w_run         = 1'b0;
        end
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign w_squash = flush_i | w_redirect;

  // Completed stores among the squashed survivors release their store-buffer slots
  always_comb begin
    w_discard = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (w_squash && r_valid[i] && !w_commit_mask[i] && r_store[i] && r_done[i])
        w_discard[r_sb_idx[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && r_valid[wb_idx_i[p*IDX_W +: IDX_W]])
          r_done[wb_idx_i[p*IDX_W +: IDX_W]] <= 1'b1;
      end
      if (w_squash) begin
        r_valid <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          if (w_commit_mask[i]) begin
            r_valid[i] <= 1'b0;
            r_done[i]  <= 1'b0;
          end
        end
        for (int k = 0; k < ALLOC_W; k++) begin
          if (w_alloc_ready && alloc_valid_i[k]) begin
            r_valid[r_tail + IDX_W'(k)] <= 1'b1;
            r_done[r_tail + IDX_W'(k)]  <= 1'b0;
          end
        end
        r_head  <= r_head + IDX_W'(w_commit_n);
        r_tail  <= r_tail + IDX_W'(w_alloc_n);
        r_count <= r_count + w_alloc_n - w_commit_n;
      end
    end
  end

  // Payload storage; only ever read behind a valid/done qualifier, so no reset needed
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p] && r_valid[wb_idx_i[p*IDX_W +: IDX_W]]) begin
        r_result[wb_idx_i[p*IDX_W +: IDX_W]] <= wb_result_i[p*32 +: 32];
        r_new_pc[wb_idx_i[p*IDX_W +: IDX_W]] <= wb_new_pc_i[p*32 +: 32];
        r_taken[wb_idx_i[p*IDX_W +: IDX_W]]  <= wb_taken_i[p];
        r_sb_idx[wb_idx_i[p*IDX_W +: IDX_W]] <= wb_sb_idx_i[p*SBI_W +: SBI_W];
      end
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      if (w_alloc_ready && alloc_valid_i[k] && !w_squash) begin
        r_pc[r_tail + IDX_W'(k)]    <= alloc_pc_i[k*32 +: 32];
        r_rd[r_tail + IDX_W'(k)]    <= alloc_rd_i[k*5 +: 5];
        r_we[r_tail + IDX_W'(k)]    <= alloc_we_i[k];
        r_store[r_tail + IDX_W'(k)] <= alloc_store_i[k];
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commit;
  logic [31:0] r_perf_stall;
  logic [32:0] w_perf_sum;

  assign w_perf_sum = {1'b0, r_perf_commit} + 33'(w_commit_n);

  // Saturating counters; flush does not clear them
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_commit <= '0;
      r_perf_stall  <= '0;
    end else begin
      r_perf_commit <= w_perf_sum[32] ? 32'hFFFF_FFFF : w_perf_sum[31:0];
      if (alloc_valid_i[0] && !w_alloc_ready && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_commit_o     = r_perf_commit;
  assign perf_full_stall_o = r_perf_stall;
`endif

  assign commit_valid_o   = w_commit;
  assign redirect_valid_o = w_redirect;
  assign redirect_pc_o    = w_redirect_pc;
  assign discard_sb_o     = w_discard;
  assign alloc_ready_o    = w_alloc_ready;
  assign count_o          = r_count;
  assign empty_o          = (r_count == '0);
  assign full_o           = (r_count == CNT_W'(ROB_DEPTH));

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi at default parameters (depth 16, 2 alloc/commit/wb lanes, 8 SB slots).
module tb_rob_multi;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic [1:0]  alloc_valid_i;
  logic [63:0] alloc_pc_i;
  logic [9:0]  alloc_rd_i;
  logic [1:0]  alloc_we_i;
  logic [1:0]  alloc_store_i;
  logic        alloc_ready_o;
  logic [7:0]  alloc_idx_o;
  logic [1:0]  wb_valid_i;
  logic [7:0]  wb_idx_i;
  logic [63:0] wb_result_i;
  logic [63:0] wb_new_pc_i;
  logic [1:0]  wb_taken_i;
  logic [5:0]  wb_sb_idx_i;
  logic [1:0]  commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [9:0]  commit_rd_o;
  logic [1:0]  commit_we_o;
  logic [63:0] commit_result_o;
  logic [1:0]  commit_store_o;
  logic [5:0]  commit_sb_idx_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [7:0]  discard_sb_o;
  logic [4:0]  count_o;
  logic        empty_o;
  logic        full_o;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_o;
  logic [31:0] perf_full_stall_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rob_multi dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_rd_i(alloc_rd_i),
    .alloc_we_i(alloc_we_i), .alloc_store_i(alloc_store_i),
    .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_new_pc_i(wb_new_pc_i), .wb_taken_i(wb_taken_i), .wb_sb_idx_i(wb_sb_idx_i),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_rd_o(commit_rd_o),
    .commit_we_o(commit_we_o), .commit_result_o(commit_result_o),
    .commit_store_o(commit_store_o), .commit_sb_idx_o(commit_sb_idx_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .discard_sb_o(discard_sb_o), .count_o(count_o), .empty_o(empty_o),
`ifdef ROB_PERF_CNT_EN
    .perf_commit_o(perf_commit_o), .perf_full_stall_o(perf_full_stall_o),
`endif
    .full_o(full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] av;
    logic [3:0] idx0;
    logic [3:0] idx1;
    logic       rdy;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    flush_i = 1'b0; alloc_valid_i = '0; alloc_pc_i = '0; alloc_rd_i = '0;
    alloc_we_i = '0; alloc_store_i = '0; wb_valid_i = '0; wb_idx_i = '0;
    wb_result_i = '0; wb_new_pc_i = '0; wb_taken_i = '0; wb_sb_idx_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Lane k gets pc = base + 4*(i0+k) and rd = i0+k
  task automatic alloc(input logic [1:0] av, input int i0, input logic [31:0] base,
                       input logic [1:0] st);
    alloc_valid_i = av;
    alloc_we_i    = av;
    alloc_store_i = st;
    for (int k = 0; k < 2; k++) begin
      alloc_pc_i[k*32 +: 32] = base + 32'(4 * ((i0 + k) % 16));
      alloc_rd_i[k*5 +: 5]   = 5'((i0 + k) % 16);
    end
  endtask

  task automatic wb(input int p, input logic [3:0] idx, input logic [31:0] res,
                    input logic [31:0] npc, input logic tk, input logic [2:0] sb);
    wb_valid_i[p]          = 1'b1;
    wb_idx_i[p*4 +: 4]     = idx;
    wb_result_i[p*32 +: 32] = res;
    wb_new_pc_i[p*32 +: 32] = npc;
    wb_taken_i[p]          = tk;
    wb_sb_idx_i[p*3 +: 3]  = sb;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{2'b11, 4'(2*i), 4'(2*i+1), 1'b1, 5'(2*i)};
    tbl[8] = '{2'b11, 4'd0, 4'd1, 1'b0, 5'd16};

    clr_in();
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_commit", 64'(commit_valid_o), 64'd0);
    chk("rst_redirect", 64'(redirect_valid_o), 64'd0);
    chk("rst_discard", 64'(discard_sb_o), 64'd0);

    // Reset in the middle of a run with five entries outstanding
    alloc(2'b11, 0, 32'h0, 2'b00); cyc();
    alloc(2'b11, 2, 32'h0, 2'b00); cyc();
    alloc(2'b01, 4, 32'h0, 2'b00); cyc();
    clr_in(); #1;
    chk("mid_count5", 64'(count_o), 64'd5);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count_o), 64'd0);
    chk("mid_rst_empty", 64'(empty_o), 64'd1);
    chk("mid_rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("mid_rst_commit", 64'(commit_valid_o), 64'd0);

    // Fill to full, then one refused allocation
    for (int i = 0; i < 9; i++) begin
      alloc(tbl[i].av, int'(tbl[i].idx0), 32'h0, 2'b00);
      #1;
      chk($sformatf("fill%0d_idx0", i), 64'(alloc_idx_o[3:0]), 64'(tbl[i].idx0));
      chk($sformatf("fill%0d_idx1", i), 64'(alloc_idx_o[7:4]), 64'(tbl[i].idx1));
      chk($sformatf("fill%0d_ready", i), 64'(alloc_ready_o), 64'(tbl[i].rdy));
      chk($sformatf("fill%0d_count", i), 64'(count_o), 64'(tbl[i].cnt));
      cyc();
    end
    clr_in(); #1;
    chk("full_flag", 64'(full_o), 64'd1);
    chk("full_count", 64'(count_o), 64'd16);

    flush_i = 1'b1; #1;
    chk("flush_commit", 64'(commit_valid_o), 64'd0);
    chk("flush_redirect", 64'(redirect_valid_o), 64'd0);
    chk("flush_discard", 64'(discard_sb_o), 64'd0);
    cyc(); clr_in(); #1;
    chk("flush_count", 64'(count_o), 64'd0);

    // Out-of-order writeback; commit waits for the head
    alloc(2'b11, 0, 32'h1000, 2'b00); cyc();
    alloc(2'b11, 2, 32'h1000, 2'b00); cyc();
    clr_in();
    wb(0, 4'd1, 32'h11, 32'h0, 1'b0, 3'd0); #1;
    chk("ooo_wait1", 64'(commit_valid_o), 64'd0);
    cyc(); clr_in();
    wb(0, 4'd0, 32'h10, 32'h0, 1'b0, 3'd0); #1;
    chk("ooo_wait2", 64'(commit_valid_o), 64'd0);
    cyc(); clr_in(); #1;
    chk("ooo_commit", 64'(commit_valid_o), 64'd3);
    chk("ooo_pc", 64'(commit_pc_o), 64'h0000_1004_0000_1000);
    chk("ooo_result", 64'(commit_result_o), 64'h0000_0011_0000_0010);
    chk("ooo_rd", 64'(commit_rd_o), 64'(10'b00001_00000));
    chk("ooo_we", 64'(commit_we_o), 64'd3);
    chk("ooo_store", 64'(commit_store_o), 64'd0);
    chk("ooo_sb", 64'(commit_sb_idx_o), 64'd0);
    chk("ooo_count_before", 64'(count_o), 64'd4);
    cyc(); #1;
    chk("ooo_count_after", 64'(count_o), 64'd2);
    flush_i = 1'b1; cyc(); clr_in(); #1;
    chk("ooo_flush_count", 64'(count_o), 64'd0);

    // Taken branch at head squashes younger entries incl. a completed store in slot 5
    alloc(2'b11, 0, 32'h3000, 2'b00); cyc();
    alloc(2'b11, 2, 32'h3000, 2'b01); cyc();
    clr_in();
    wb(0, 4'd0, 32'h0, 32'h100, 1'b1, 3'd0);
    wb(1, 4'd2, 32'h0, 32'h0, 1'b0, 3'd5);
    cyc(); clr_in();
    alloc(2'b11, 4, 32'h3000, 2'b11); #1;
    chk("br_commit", 64'(commit_valid_o), 64'd1);
    chk("br_pc", 64'(commit_pc_o[31:0]), 64'h3000);
    chk("br_redirect", 64'(redirect_valid_o), 64'd1);
    chk("br_redirect_pc", 64'(redirect_pc_o), 64'h100);
    chk("br_discard", 64'(discard_sb_o), 64'h20);
    cyc(); clr_in(); #1;
    chk("br_count", 64'(count_o), 64'd0);
    chk("br_empty", 64'(empty_o), 64'd1);

    // Advance head to 14, then commit across the wrap
    for (int i = 0; i < 7; i++) begin
      alloc(2'b11, 2*i, 32'h4000, 2'b00); cyc();
    end
    clr_in();
    for (int i = 0; i < 7; i++) begin
      clr_in();
      wb(0, 4'(2*i), 32'h0, 32'h0, 1'b0, 3'd0);
      wb(1, 4'(2*i+1), 32'h0, 32'h0, 1'b0, 3'd0);
      cyc();
    end
    clr_in();
    for (int t = 0; t < 20 && count_o != 5'd0; t++) cyc();
    chk("wrap_drain", 64'(count_o), 64'd0);
    alloc(2'b11, 14, 32'h4000, 2'b00); #1;
    chk("wrap_idx_a", 64'(alloc_idx_o), 64'hFE);
    cyc();
    alloc(2'b11, 0, 32'h4000, 2'b00); #1;
    chk("wrap_idx_b", 64'(alloc_idx_o), 64'h10);
    cyc(); clr_in();
    wb(0, 4'd14, 32'h0, 32'h0, 1'b0, 3'd0);
    wb(1, 4'd15, 32'h0, 32'h0, 1'b0, 3'd0);
    cyc(); clr_in();
    wb(0, 4'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    wb(1, 4'd1, 32'h0, 32'h0, 1'b0, 3'd0); #1;
    chk("wrap_commit_a", 64'(commit_valid_o), 64'd3);
    chk("wrap_pc_a", 64'(commit_pc_o), 64'h0000_403C_0000_4038);
    cyc(); clr_in(); #1;
    chk("wrap_commit_b", 64'(commit_valid_o), 64'd3);
    chk("wrap_pc_b", 64'(commit_pc_o), 64'h0000_4004_0000_4000);
    cyc(); #1;
    chk("wrap_count", 64'(count_o), 64'd0);
    chk("wrap_tail2", 64'(alloc_idx_o[3:0]), 64'd2);

    // Invalid-entry writeback is dropped; duplicate writeback resolves to port 1
    wb(0, 4'd3, 32'hDEAD, 32'h0, 1'b1, 3'd0); #1;
    chk("inv_commit", 64'(commit_valid_o), 64'd0);
    cyc(); clr_in(); #1;
    chk("inv_count", 64'(count_o), 64'd0);
    chk("inv_empty", 64'(empty_o), 64'd1);
    alloc(2'b11, 2, 32'h5000, 2'b00); cyc(); clr_in();
    wb(0, 4'd2, 32'hAAAA, 32'h0, 1'b0, 3'd0);
    wb(1, 4'd2, 32'hBBBB, 32'h0, 1'b0, 3'd0); #1;
    chk("dup_wait", 64'(commit_valid_o), 64'd0);
    cyc(); clr_in(); #1;
    chk("dup_commit", 64'(commit_valid_o), 64'd1);
    chk("dup_result", 64'(commit_result_o[31:0]), 64'hBBBB);
    chk("dup_pc", 64'(commit_pc_o[31:0]), 64'h5008);
    chk("dup_redirect", 64'(redirect_valid_o), 64'd0);
    cyc(); #1;
    chk("dup_count", 64'(count_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
